counter_min_hour: RTL and testbench



---
 rtl/counter_min_hour.sv | 94 +++++++++
 tb/tb_counter_min_hour.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_min_hour.sv
// Minutes/hours stage of the clock chain; 12-hour AM/PM build selected by CLOCK_12H_EN.
// Latency: counts update on the edge after carry_sec/load; carry_min/carry_day are same-cycle combinational.
// Backpressure: none; enable_min=0 drops carry_sec pulses, and a held load freezes its field.
module counter_min_hour (
  input  logic       clock,
  input  logic       reset_min_n,
  input  logic       carry_sec,
  input  logic       enable_min,
  input  logic       load_min,
  input  logic [5:0] data_min,
  input  logic       load_hour,
  input  logic [4:0] data_hour,
  output logic [5:0] count_min,
  output logic [4:0] count_hour,
  output logic       pm,
  output logic       carry_min,
  output logic       carry_day
);

  logic       inc;
  logic       hour_last;
  logic [5:0] min_load_val;
  logic [4:0] hour_in;

  assign inc          = carry_sec & enable_min;
  assign min_load_val = (data_min > 6'd59) ? 6'd0 : data_min;
  assign hour_in      = (data_hour > 5'd23) ? 5'd0 : data_hour;

  // A minute load on the wrap cycle swallows the carry, so hours hold.
  assign carry_min = inc & ~load_min & (count_min == 6'd59);
  assign carry_day = carry_min & ~load_hour & hour_last;

  always_ff @(posedge clock or negedge reset_min_n) begin
    if (!reset_min_n) begin
      count_min <= 6'd0;
    end else if (load_min) begin
      count_min <= min_load_val;
    end else if (inc) begin
      count_min <= (count_min == 6'd59) ? 6'd0 : count_min + 6'd1;
    end
  end

`ifdef CLOCK_12H_EN
  logic       pm_q;
  logic [4:0] hour_load_val;
  logic       pm_load_val;

  // 24-hour load value to 12-hour display: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
  always_comb begin
    hour_load_val = hour_in;
    pm_load_val   = 1'b0;
    if (hour_in == 5'd0) begin
      hour_load_val = 5'd12;
    end else if (hour_in >= 5'd12) begin
      pm_load_val = 1'b1;
      if (hour_in != 5'd12) hour_load_val = hour_in - 5'd12;
    end
  end

  assign hour_last = pm_q & (count_hour == 5'd11);
  assign pm        = pm_q;

  always_ff @(posedge clock or negedge reset_min_n) begin
    if (!reset_min_n) begin
      count_hour <= 5'd12;
      pm_q       <= 1'b0;
    end else if (load_hour) begin
      count_hour <= hour_load_val;
      pm_q       <= pm_load_val;
    end else if (carry_min) begin
      if (count_hour == 5'd12) begin
        count_hour <= 5'd1;
      end else begin
        count_hour <= count_hour + 5'd1;
        if (count_hour == 5'd11) pm_q <= ~pm_q;
      end
    end
  end
`else
  assign hour_last = (count_hour == 5'd23);
  assign pm        = 1'b0;

  always_ff @(posedge clock or negedge reset_min_n) begin
    if (!reset_min_n) begin
      count_hour <= 5'd0;
    end else if (load_hour) begin
      count_hour <= hour_in;
    end else if (carry_min) begin
      count_hour <= (count_hour == 5'd23) ? 5'd0 : count_hour + 5'd1;
    end
  end
`endif

endmodule

// File: tb/tb_counter_min_hour.sv
// Bench for counter_min_hour; reference keeps a single minute-of-day count and derives the display.
module tb_counter_min_hour;

  logic       clock = 1'b0;
  logic       reset_min_n = 1'b0;
  logic       carry_sec = 1'b0;
  logic       enable_min = 1'b0;
  logic       load_min = 1'b0;
  logic [5:0] data_min = 6'd0;
  logic       load_hour = 1'b0;
  logic [4:0] data_hour = 5'd0;
  logic [5:0] count_min;
  logic [4:0] count_hour;
  logic       pm;
  logic       carry_min;
  logic       carry_day;

  counter_min_hour dut (
    .clock      (clock),
    .reset_min_n(reset_min_n),
    .carry_sec  (carry_sec),
    .enable_min (enable_min),
    .load_min   (load_min),
    .data_min   (data_min),
    .load_hour  (load_hour),
    .data_hour  (data_hour),
    .count_min  (count_min),
    .count_hour (count_hour),
    .pm         (pm),
    .carry_min  (carry_min),
    .carry_day  (carry_day)
  );

  always #5 clock = ~clock;

  typedef struct {
    int mins;
    int hour;
    int pm;
  } exp_t;

  exp_t exp_q[$];
  int   tod = 0;  // reference time as minutes since midnight
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int disp_hour(input int h24);
`ifdef CLOCK_12H_EN
    return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
    return h24;
`endif
  endfunction

  function automatic int disp_pm(input int h24);
`ifdef CLOCK_12H_EN
    return (h24 >= 12) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic exp_t model_view(input int t);
    exp_t e;
    e.mins = t % 60;
    e.hour = disp_hour(t / 60);
    e.pm   = disp_pm(t / 60);
    return e;
  endfunction

  task automatic check_counts(input string tag, input exp_t e);
    check({tag, ".min"}, int'(count_min), e.mins);
    check({tag, ".hour"}, int'(count_hour), e.hour);
    check({tag, ".pm"}, int'(pm), e.pm);
  endtask

  // One clock: drive at negedge, check carries before the edge, queue the post-edge state, check after.
  task automatic step(input bit cs, input bit en, input bit lm, input int dm,
                      input bit lh, input int dh);
    int  m, h;
    bit  inc, cm, cd;
    exp_t e;
    @(negedge clock);
    reset_min_n = 1'b1;
    carry_sec   = cs;
    enable_min  = en;
    load_min    = lm;
    data_min    = 6'(dm);
    load_hour   = lh;
    data_hour   = 5'(dh);
    #1;
    m   = tod % 60;
    h   = tod / 60;
    inc = cs & en;
    cm  = inc & !lm & (m == 59);
    cd  = cm & !lh & (h == 23);
    check("carry_min", int'(carry_min), int'(cm));
    check("carry_day", int'(carry_day), int'(cd));
    if (lm) m = (dm > 59) ? 0 : dm;
    else if (inc) m = (m + 1) % 60;
    if (lh) h = (dh > 23) ? 0 : dh;
    else if (cm) h = (h + 1) % 24;
    tod = h * 60 + m;
    exp_q.push_back(model_view(tod));
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_counts("cnt", e);
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0);
  endtask

  task automatic load_time(input int h, input int m);
    step(0, 1, 1, m, 1, h);
  endtask

  initial begin
    #1;
    check_counts("reset", model_view(0));
    check("reset.carry_min", int'(carry_min), 0);

    // 60 minute pulses: full minute wrap into hour 1
    pulse(60);
    check_counts("hour1", model_view(60));

    // 23:59 wrap to midnight in one edge
    load_time(23, 59);
    pulse(1);
    check_counts("midnight", model_view(0));

    // disabled pulses are ignored, then counting resumes
    pulse(3);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
    pulse(5);

    // minute load beats increment on the wrap cycle
    load_time(7, 59);
    step(1, 1, 1, 10, 0, 0);
    check_counts("ld_on_wrap", model_view(7 * 60 + 10));
    step(0, 1, 1, 63, 0, 0);
    step(1, 1, 0, 0, 1, 31);
    load_time(5, 59);
    step(1, 1, 0, 0, 1, 9);

    // async reset mid-count at 14:37
    load_time(14, 37);
    pulse(2);
    #3;
    reset_min_n = 1'b0;
    carry_sec   = 1'b0;
    #1;
    tod = 0;
    check_counts("async_rst", model_view(0));
    step(0, 1, 0, 0, 0, 0);
    check_counts("rel_idle", model_view(0));
    pulse(1);
    #3;
    reset_min_n = 1'b0;
    #1;
    tod = 0;
    check_counts("async_rst2", model_view(0));
    step(1, 1, 0, 0, 0, 0);
    check_counts("rel_inc", model_view(1));

    // noon / afternoon boundaries and hour load conversion
    load_time(11, 59);
    pulse(1);
    load_time(12, 59);
    pulse(1);
    load_time(0, 59);
    pulse(1);
    load_time(13, 0);
    load_time(24, 0);
    load_time(22, 59);
    pulse(61);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63),
           $urandom_range(0, 15) == 0, $urandom_range(0, 31));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
